// File: rtl/img_window_scanner_if.sv
// img_window_scanner_if
//  Bundles the pixel-load handshake, the window-stream handshake and the
//  status pins of img_window_scanner into one interface.
//  Ports carried:
//   start, ksize        frame start and kernel size (0 = 3x3, 1 = 5x5)
//   pixel_in, in_valid  LANES pixels per beat, raster order
//   in_ready            scanner accepts pixel beats
//   win_out             25-element window, element (dy,dx) at (dy+2)*5+(dx+2)
//   win_row, win_col    centre coordinates of win_out
//   win_valid/win_ready window stream handshake
//   busy, frame_done    status
//  slave modport = the scanner, master modport = whoever drives it.
interface img_window_scanner_if #(
   parameter int BIT_LENGTH = 5,
   parameter int IMG_DIM    = 20,
   parameter int LANES      = 5
);
   logic                          start;
   logic                          ksize;
   logic [LANES*BIT_LENGTH-1:0]   pixel_in;
   logic                          in_valid;
   logic                          in_ready;
   logic [25*BIT_LENGTH-1:0]      win_out;
   logic [$clog2(IMG_DIM)-1:0]    win_row;
   logic [$clog2(IMG_DIM)-1:0]    win_col;
   logic                          win_valid;
   logic                          win_ready;
   logic                          busy;
   logic                          frame_done;

   modport slave (
      input  start, ksize, pixel_in, in_valid, win_ready,
      output in_ready, win_out, win_row, win_col, win_valid, busy, frame_done
   );

   modport master (
      output start, ksize, pixel_in, in_valid, win_ready,
      input  in_ready, win_out, win_row, win_col, win_valid, busy, frame_done
   );
endinterface

// File: rtl/img_window_scanner.sv
// img_window_scanner
//  Frame buffer plus kernel-window generator. A frame of IMG_DIM x IMG_DIM
//  pixels is loaded LANES pixels per beat, then one KxK neighbourhood per
//  pixel is streamed out in raster order with edge replication at borders.
//  In 3x3 mode the outer ring of the 5x5 window is forced to zero.
//  Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, aborts any frame in progress
//   bus    img_window_scanner_if.slave (load handshake, window stream, status)
module img_window_scanner #(
   parameter int BIT_LENGTH = 5,
   parameter int IMG_DIM    = 20,
   parameter int LANES      = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   img_window_scanner_if.slave   bus
);

   localparam int NPIX    = IMG_DIM * IMG_DIM;
   localparam int IDX_W   = $clog2(NPIX);
   localparam int COORD_W = $clog2(IMG_DIM);
   localparam logic [IDX_W-1:0]   LAST_BEAT  = IDX_W'(NPIX - LANES);
   localparam logic [IDX_W-1:0]   LANE_STEP  = IDX_W'(LANES);
   localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(IMG_DIM - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

   state_t state, next_state;

   logic [NPIX*BIT_LENGTH-1:0] frame_store;
   logic [IDX_W-1:0]           load_index;
   logic                       ksize_r;
   logic [COORD_W-1:0]         scan_row, scan_col;
   logic                       issue_done;
   logic [25*BIT_LENGTH-1:0]   win_out_r, win_next;
   logic [COORD_W-1:0]         win_row_r, win_col_r;
   logic                       win_valid_r;

   logic beat, last_beat, out_load, last_accept;

   assign beat        = (state == LOAD) && bus.in_valid;
   assign last_beat   = beat && (load_index == LAST_BEAT);
   assign out_load    = (state == SCAN) && !issue_done && (!win_valid_r || bus.win_ready);
   assign last_accept = (state == SCAN) && issue_done && win_valid_r && bus.win_ready;

   // Clamped source address of a window element; clamping to the frame
   // edge is what replicates border pixels.
   function automatic logic [IDX_W-1:0] src_addr(input int r, input int c);
      int rr, cc;
      rr = (r < 0) ? 0 : ((r > IMG_DIM - 1) ? IMG_DIM - 1 : r);
      cc = (c < 0) ? 0 : ((c > IMG_DIM - 1) ? IMG_DIM - 1 : c);
      return IDX_W'(rr * IMG_DIM + cc);
   endfunction

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic. Loading ends by counting beats, scanning ends when
   // the final window has been handed downstream.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = LOAD;
         LOAD:    if (last_beat) next_state = SCAN;
         SCAN:    if (last_accept) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Assemble the window centred on the next pixel to issue. Ring elements
   // are left at zero when a 3x3 kernel was selected.
   always_comb begin
      win_next = '0;
      for (int dy = -2; dy <= 2; dy++) begin
         for (int dx = -2; dx <= 2; dx++) begin
            if (ksize_r || !(dy == -2 || dy == 2 || dx == -2 || dx == 2)) begin
               win_next[((dy + 2) * 5 + (dx + 2)) * BIT_LENGTH +: BIT_LENGTH] =
                  frame_store[int'(src_addr(int'(scan_row) + dy, int'(scan_col) + dx)) * BIT_LENGTH +: BIT_LENGTH];
            end
         end
      end
   end

   // Datapath: frame store writes, scan counters and the output register.
   // The output register refills whenever it is empty or being drained, so
   // a held-high win_ready gives one window per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_store <= '0;
         load_index  <= '0;
         ksize_r     <= 1'b0;
         scan_row    <= '0;
         scan_col    <= '0;
         issue_done  <= 1'b0;
         win_out_r   <= '0;
         win_row_r   <= '0;
         win_col_r   <= '0;
         win_valid_r <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            ksize_r    <= bus.ksize;
            load_index <= '0;
         end
         if (beat) begin
            for (int i = 0; i < LANES; i++) begin
               frame_store[(int'(load_index) + i) * BIT_LENGTH +: BIT_LENGTH] <=
                  bus.pixel_in[i * BIT_LENGTH +: BIT_LENGTH];
            end
            load_index <= last_beat ? '0 : load_index + LANE_STEP;
         end
         if (last_beat) begin
            scan_row   <= '0;
            scan_col   <= '0;
            issue_done <= 1'b0;
         end
         if (out_load) begin
            win_out_r   <= win_next;
            win_row_r   <= scan_row;
            win_col_r   <= scan_col;
            win_valid_r <= 1'b1;
            if (scan_col == LAST_COORD) begin
               scan_col <= '0;
               if (scan_row == LAST_COORD) issue_done <= 1'b1;
               else                        scan_row   <= scan_row + 1'b1;
            end else begin
               scan_col <= scan_col + 1'b1;
            end
         end else if (win_valid_r && bus.win_ready) begin
            win_valid_r <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = (state == LOAD);
   assign bus.busy       = (state != IDLE);
   assign bus.frame_done = (state == DONE);
   assign bus.win_out    = win_out_r;
   assign bus.win_row    = win_row_r;
   assign bus.win_col    = win_col_r;
   assign bus.win_valid  = win_valid_r;

endmodule

// File: tb/tb_img_window_scanner.sv
// tb_img_window_scanner
//  Directed bench for img_window_scanner using a ramp frame
//  p[r][c] = (r*20+c) % 32. Expected windows come from a small clamped
//  neighbourhood model of that ramp; corner values are also written out
//  as hand-computed constants.
module tb_img_window_scanner;

   localparam int BL    = 5;
   localparam int DIM   = 20;
   localparam int LANES = 5;
   localparam int NPIX  = DIM * DIM;
   localparam int WW    = 25 * BL;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   img_window_scanner_if #(.BIT_LENGTH(BL), .IMG_DIM(DIM), .LANES(LANES)) bus ();

   img_window_scanner #(.BIT_LENGTH(BL), .IMG_DIM(DIM), .LANES(LANES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int pass_count  = 0;
   int check_count = 0;

   // Captured scan results.
   logic [WW-1:0] got_win [NPIX];
   int            got_row [NPIX];
   int            got_col [NPIX];
   int            n_acc, scan_cycles, hold_errs, in_ready_high;
   bit            done_seen;

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ramp(input int r, input int c);
      return (r * DIM + c) % 32;
   endfunction

   // Reference window for centre (r,c) on the ramp frame.
   function automatic logic [WW-1:0] exp_window(input int r, input int c, input bit k5);
      logic [WW-1:0] w;
      int rr, cc, v;
      w = '0;
      for (int dy = -2; dy <= 2; dy++) begin
         for (int dx = -2; dx <= 2; dx++) begin
            if (k5 || (dy > -2 && dy < 2 && dx > -2 && dx < 2)) begin
               rr = r + dy; cc = c + dx;
               if (rr < 0) rr = 0;
               if (rr > DIM - 1) rr = DIM - 1;
               if (cc < 0) cc = 0;
               if (cc > DIM - 1) cc = DIM - 1;
               v = ramp(rr, cc);
               w[((dy + 2) * 5 + (dx + 2)) * BL +: BL] = v[BL-1:0];
            end
         end
      end
      return w;
   endfunction

   function automatic int elem(input logic [WW-1:0] w, input int idx);
      return int'(w[idx * BL +: BL]);
   endfunction

   // Number of captured windows that differ from the model or break raster order.
   function automatic int window_errs(input bit k5);
      int errs;
      errs = 0;
      for (int k = 0; k < NPIX; k++) begin
         if (got_win[k] !== exp_window(k / DIM, k % DIM, k5) ||
             got_row[k] != k / DIM || got_col[k] != k % DIM) errs++;
      end
      return errs;
   endfunction

   // Starts a frame and pushes the ramp in; gaps inserts an idle cycle
   // between beats. Returns cycles spent in LOAD and cycles where in_ready was low.
   task automatic load_frame(input bit k5, input bit gaps, output int cycles, output int not_ready);
      cycles = 0;
      not_ready = 0;
      bus.start = 1'b1;
      bus.ksize = k5;
      step();
      bus.start = 1'b0;
      bus.ksize = 1'b0;
      for (int b = 0; b < NPIX / LANES; b++) begin
         if (!bus.in_ready) not_ready++;
         bus.in_valid = 1'b1;
         for (int i = 0; i < LANES; i++) begin
            int v;
            v = (b * LANES + i) % 32;
            bus.pixel_in[i * BL +: BL] = v[BL-1:0];
         end
         step();
         cycles++;
         if (gaps && b != NPIX / LANES - 1) begin
            bus.in_valid = 1'b0;
            step();
            cycles++;
         end
      end
      bus.in_valid = 1'b0;
      bus.pixel_in = '0;
   endtask

   // Drives win_ready in SCAN and records accepted windows.
   //  mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: ready 1 with
   //  start/in_valid/ksize pulses in the first cycles. stop_at >= 0 returns
   //  once that many windows have been accepted.
   task automatic run_scan(input int mode, input int stop_at);
      logic [WW-1:0] held_win;
      int held_row, held_col;
      bit holding;
      holding = 1'b0;
      held_win = '0; held_row = 0; held_col = 0;
      n_acc = 0; scan_cycles = 0; hold_errs = 0; in_ready_high = 0; done_seen = 1'b0;
      while (!done_seen && scan_cycles < 2000) begin
         if (stop_at >= 0 && n_acc == stop_at) return;
         if (mode == 1) bus.win_ready = (scan_cycles % 4 == 0) || (scan_cycles % 4 == 3);
         else           bus.win_ready = 1'b1;
         if (mode == 2 && scan_cycles <= 2) begin
            bus.start = 1'b1; bus.in_valid = 1'b1; bus.ksize = 1'b1; bus.pixel_in = '1;
         end else begin
            bus.start = 1'b0; bus.in_valid = 1'b0; bus.ksize = 1'b0; bus.pixel_in = '0;
         end
         if (bus.in_ready) in_ready_high++;
         if (holding && (!bus.win_valid || bus.win_out !== held_win ||
                         int'(bus.win_row) != held_row || int'(bus.win_col) != held_col))
            hold_errs++;
         holding = bus.win_valid && !bus.win_ready;
         if (holding) begin
            held_win = bus.win_out; held_row = int'(bus.win_row); held_col = int'(bus.win_col);
         end
         if (bus.win_valid && bus.win_ready) begin
            if (n_acc < NPIX) begin
               got_win[n_acc] = bus.win_out;
               got_row[n_acc] = int'(bus.win_row);
               got_col[n_acc] = int'(bus.win_col);
            end
            n_acc++;
         end
         step();
         scan_cycles++;
         if (bus.frame_done) done_seen = 1'b1;
      end
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.ksize = 1'b0; bus.pixel_in = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      check_count++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.frame_done !== 1'b0) begin
         $display("[TB] FAIL reset_status: busy=%b in_ready=%b frame_done=%b, required 0 0 0",
                  bus.busy, bus.in_ready, bus.frame_done);
      end else pass_count++;
      check_count++;
      if (bus.win_valid !== 1'b0 || bus.win_out !== '0 || bus.win_row !== '0 || bus.win_col !== '0) begin
         $display("[TB] FAIL reset_window: win_valid=%b win_out=%h row=%0d col=%0d, required all 0",
                  bus.win_valid, bus.win_out, bus.win_row, bus.win_col);
      end else pass_count++;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_ramp_3x3();
      int cyc, nr, errs;
      load_frame(1'b0, 1'b0, cyc, nr);
      run_scan(0, -1);
      check_count++;
      if (n_acc !== NPIX || !done_seen) begin
         $display("[TB] FAIL k3_count: windows=%0d done=%0b, required %0d 1", n_acc, done_seen, NPIX);
      end else pass_count++;
      check_count++;
      if (scan_cycles !== NPIX + 1) begin
         $display("[TB] FAIL k3_throughput: cycles=%0d, required %0d", scan_cycles, NPIX + 1);
      end else pass_count++;
      // Window (0,0): centre 0, up-left clamped to 0, right 1, down-right p[1][1]=21.
      check_count++;
      if (elem(got_win[0], 12) !== 0 || elem(got_win[0], 6) !== 0 ||
          elem(got_win[0], 13) !== 1 || elem(got_win[0], 18) !== 21) begin
         $display("[TB] FAIL k3_win00: idx12=%0d idx6=%0d idx13=%0d idx18=%0d, required 0 0 1 21",
                  elem(got_win[0], 12), elem(got_win[0], 6), elem(got_win[0], 13), elem(got_win[0], 18));
      end else pass_count++;
      // Window (19,19): ring forced to 0 though p[17][17]=5, p[17][19]=7.
      check_count++;
      if (elem(got_win[NPIX-1], 0) !== 0 || elem(got_win[NPIX-1], 4) !== 0 ||
          elem(got_win[NPIX-1], 12) !== 15) begin
         $display("[TB] FAIL k3_ring: idx0=%0d idx4=%0d idx12=%0d, required 0 0 15",
                  elem(got_win[NPIX-1], 0), elem(got_win[NPIX-1], 4), elem(got_win[NPIX-1], 12));
      end else pass_count++;
      errs = window_errs(1'b0);
      check_count++;
      if (errs !== 0) begin
         $display("[TB] FAIL k3_windows: bad windows=%0d, required 0", errs);
      end else pass_count++;
      step();
      check_count++;
      if (bus.busy !== 1'b0 || bus.win_valid !== 1'b0) begin
         $display("[TB] FAIL k3_idle: busy=%b win_valid=%b, required 0 0", bus.busy, bus.win_valid);
      end else pass_count++;
   endtask

   task automatic test_ramp_5x5();
      int cyc, nr, errs;
      load_frame(1'b1, 1'b0, cyc, nr);
      run_scan(0, -1);
      // Window (19,19): p[19][19]=399%32=15, p[17][17]=357%32=5, p[17][19]=359%32=7.
      check_count++;
      if (elem(got_win[NPIX-1], 12) !== 15 || elem(got_win[NPIX-1], 24) !== 15 ||
          elem(got_win[NPIX-1], 0) !== 5 || elem(got_win[NPIX-1], 4) !== 7) begin
         $display("[TB] FAIL k5_win1919: idx12=%0d idx24=%0d idx0=%0d idx4=%0d, required 15 15 5 7",
                  elem(got_win[NPIX-1], 12), elem(got_win[NPIX-1], 24),
                  elem(got_win[NPIX-1], 0), elem(got_win[NPIX-1], 4));
      end else pass_count++;
      errs = window_errs(1'b1);
      check_count++;
      if (errs !== 0 || n_acc !== NPIX) begin
         $display("[TB] FAIL k5_windows: bad windows=%0d count=%0d, required 0 %0d", errs, n_acc, NPIX);
      end else pass_count++;
      step();
   endtask

   task automatic test_ready_toggle();
      int cyc, nr, errs;
      load_frame(1'b0, 1'b0, cyc, nr);
      run_scan(1, -1);
      check_count++;
      if (hold_errs !== 0) begin
         $display("[TB] FAIL toggle_hold: unstable held cycles=%0d, required 0", hold_errs);
      end else pass_count++;
      errs = window_errs(1'b0);
      check_count++;
      if (errs !== 0 || n_acc !== NPIX || !done_seen) begin
         $display("[TB] FAIL toggle_windows: bad=%0d count=%0d done=%0b, required 0 %0d 1",
                  errs, n_acc, done_seen, NPIX);
      end else pass_count++;
      step();
   endtask

   task automatic test_load_gaps();
      int cyc, nr, errs;
      load_frame(1'b0, 1'b1, cyc, nr);
      check_count++;
      if (cyc !== 159 || nr !== 0 || bus.in_ready !== 1'b0) begin
         $display("[TB] FAIL gaps_load: cycles=%0d ready_low=%0d in_ready=%b, required 159 0 0",
                  cyc, nr, bus.in_ready);
      end else pass_count++;
      run_scan(0, -1);
      errs = window_errs(1'b0);
      check_count++;
      if (errs !== 0 || n_acc !== NPIX) begin
         $display("[TB] FAIL gaps_windows: bad=%0d count=%0d, required 0 %0d", errs, n_acc, NPIX);
      end else pass_count++;
      step();
   endtask

   task automatic test_ignored_inputs();
      int cyc, nr, errs;
      load_frame(1'b0, 1'b0, cyc, nr);
      run_scan(2, -1);
      check_count++;
      if (in_ready_high !== 0) begin
         $display("[TB] FAIL ignore_in_ready: cycles with in_ready=1 is %0d, required 0", in_ready_high);
      end else pass_count++;
      errs = window_errs(1'b0);
      check_count++;
      if (errs !== 0 || n_acc !== NPIX) begin
         $display("[TB] FAIL ignore_windows: bad=%0d count=%0d, required 0 %0d", errs, n_acc, NPIX);
      end else pass_count++;
      step();
      check_count++;
      if (bus.busy !== 1'b0) begin
         $display("[TB] FAIL ignore_state: busy=%b after frame, required 0", bus.busy);
      end else pass_count++;
   endtask

   task automatic test_reset_midscan();
      int cyc, nr, errs;
      load_frame(1'b0, 1'b0, cyc, nr);
      run_scan(0, 37);
      check_count++;
      if (bus.win_valid !== 1'b1 || int'(bus.win_row) != 1 || int'(bus.win_col) != 17) begin
         $display("[TB] FAIL midscan_pos: win_valid=%b row=%0d col=%0d, required 1 1 17",
                  bus.win_valid, bus.win_row, bus.win_col);
      end else pass_count++;
      reset = 1'b1;
      #1;
      check_count++;
      if (bus.win_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         $display("[TB] FAIL midscan_reset: win_valid=%b busy=%b in_ready=%b, required 0 0 0",
                  bus.win_valid, bus.busy, bus.in_ready);
      end else pass_count++;
      step();
      reset = 1'b0;
      step();
      step();
      check_count++;
      if (bus.win_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
         $display("[TB] FAIL midscan_after: win_valid=%b busy=%b frame_done=%b, required 0 0 0",
                  bus.win_valid, bus.busy, bus.frame_done);
      end else pass_count++;
      load_frame(1'b0, 1'b0, cyc, nr);
      run_scan(0, -1);
      errs = window_errs(1'b0);
      check_count++;
      if (errs !== 0 || n_acc !== NPIX || !done_seen) begin
         $display("[TB] FAIL midscan_refresh: bad=%0d count=%0d done=%0b, required 0 %0d 1",
                  errs, n_acc, done_seen, NPIX);
      end else pass_count++;
      step();
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.ksize     = 1'b0;
      bus.pixel_in  = '0;
      bus.in_valid  = 1'b0;
      bus.win_ready = 1'b0;
      test_reset();
      test_ramp_3x3();
      test_ramp_5x5();
      test_ready_toggle();
      test_load_gaps();
      test_ignored_inputs();
      test_reset_midscan();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
